// File: rtl/mod_gen_pkg.sv
// Shared definitions for the modulation signal generator.
//  - state_e       : FSM state encoding (IDLE=0, RUN=1, DRAIN=2)
//  - HalfW         : width of the half-period register and half counter
//  - DefHalfPer*   : default fast/slow half-periods in CLK cycles
package mod_gen_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam int unsigned HalfW       = 8;
  localparam int unsigned DefHalfPerHi = 2;
  localparam int unsigned DefHalfPerLo = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//  clk - destination clock
//  rst - asynchronous active-high reset, clears both flops to 0
//  d   - asynchronous input level
//  q   - synchronised level, two clk cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/modulation_signal_gen.sv
// Bursted complementary modulation waveform generator, running on a PLL output clock.
// A burst is NUM_PERIODS periods of MOD_OUT high for H cycles then low for H cycles, where H is
// chosen by FLAG_HIGH_FREQ at start. Bursts refuse to start, and abort, without PLL lock.
// Ports:
//  CLK, RESET      - clock, asynchronous active-high reset
//  LOCKED          - PLL lock, asynchronous (synchronised internally)
//  FLAG_HIGH_FREQ  - 1 selects HALF_PER_HI, 0 selects HALF_PER_LO (latched at start)
//  START, STOP     - single-cycle burst request / graceful stop request
//  NUM_PERIODS     - periods per burst, 0 = free-run until STOP (latched at start)
//  MOD_OUT(_N)     - waveform and its complement (both 0 when idle)
//  PERIOD_TICK     - pulse on the last low cycle of each period
//  BUSY, DONE      - burst active / normal-end pulse
//  ERR_UNLOCK      - sticky lock-loss flag, cleared by the next accepted start
module modulation_signal_gen
  import mod_gen_pkg::*;
#(
  parameter int unsigned HALF_PER_HI = DefHalfPerHi,
  parameter int unsigned HALF_PER_LO = DefHalfPerLo,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOCKED,
  input  logic             FLAG_HIGH_FREQ,
  input  logic             START,
  input  logic             STOP,
  input  logic [CNT_W-1:0] NUM_PERIODS,
  output logic             MOD_OUT,
  output logic             MOD_OUT_N,
  output logic             PERIOD_TICK,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR_UNLOCK
);

  localparam logic [HalfW-1:0] HalfHi = HalfW'(HALF_PER_HI);
  localparam logic [HalfW-1:0] HalfLo = HalfW'(HALF_PER_LO);

  logic locked_s;

  sync_2ff u_lock_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (LOCKED),
    .q   (locked_s)
  );

  state_e           state_q, state_d;
  logic [HalfW-1:0] half_q, half_d;
  logic [HalfW-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             phase_q, phase_d;  // 1 = high half of the period; forced 0 when idle
  logic             mod_out_n_q, mod_out_n_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic active;
  logic half_last;
  logic tick;
  logic terminal;
  logic done;

  assign active    = (state_q != StIdle);
  assign half_last = (hcnt_q == half_q - HalfW'(1));
  assign tick      = active && !phase_q && half_last;
  assign terminal  = (num_q != '0) && ((pcnt_q + CNT_W'(1)) == num_q);
  // STOP reaches DONE combinationally so a STOP on the tick cycle ends the burst there.
  // Lock loss suppresses DONE even when the burst would otherwise end this cycle.
  assign done      = tick && locked_s && (terminal || (state_q == StDrain) || STOP);

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    hcnt_d  = hcnt_q;
    num_d   = num_q;
    pcnt_d  = pcnt_q;
    phase_d = phase_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (START && locked_s) begin
          state_d = StRun;
          half_d  = FLAG_HIGH_FREQ ? HalfHi : HalfLo;
          num_d   = NUM_PERIODS;
          hcnt_d  = '0;
          pcnt_d  = '0;
          phase_d = 1'b1;
          err_d   = 1'b0;
        end
      end
      StRun, StDrain: begin
        if (!locked_s) begin
          state_d = StIdle;
          hcnt_d  = '0;
          phase_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          if (half_last) begin
            hcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            hcnt_d = hcnt_q + HalfW'(1);
          end
          // Free-run bursts wrap silently here.
          if (tick) begin
            pcnt_d = pcnt_q + CNT_W'(1);
          end
          if (done) begin
            state_d = StIdle;
            hcnt_d  = '0;
            phase_d = 1'b0;
          end else if ((state_q == StRun) && STOP) begin
            state_d = StDrain;
          end
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = 1'b0;
      end
    endcase

    busy_d      = (state_d != StIdle);
    mod_out_n_d = busy_d && !phase_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      half_q      <= '0;
      hcnt_q      <= '0;
      num_q       <= '0;
      pcnt_q      <= '0;
      phase_q     <= 1'b0;
      mod_out_n_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      hcnt_q      <= hcnt_d;
      num_q       <= num_d;
      pcnt_q      <= pcnt_d;
      phase_q     <= phase_d;
      mod_out_n_q <= mod_out_n_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign MOD_OUT     = phase_q;
  assign MOD_OUT_N   = mod_out_n_q;
  assign BUSY        = busy_q;
  assign PERIOD_TICK = tick;
  assign DONE        = done;
  assign ERR_UNLOCK  = err_q;

endmodule
